// File: rtl/i2c_master_byte.sv
// i2c_master_byte: single-byte I2C bus master.
// Generates START, {addr, rw}, one data byte and STOP, and checks the slave
// acknowledges. One transaction per accepted start pulse.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   divisor       quarter-bit phase length minus one (sampled at start)
//   start         one-cycle request, accepted only in IDLE and not with done
//   addr, rw      7-bit target address and direction (1 = read), sampled at start
//   wdata         write byte, sampled at start
//   busy          high while a transaction is in flight
//   done          one-cycle pulse at transaction end
//   rdata         read byte, updated only on successful read completion
//   ack_err       NACK seen (address, or data on write); valid with done
//   scl           push-pull bus clock
//   sda           open-drain bus data: drives 0 or z
//
// state   | meaning
// IDLE    | bus released, waiting for start
// START_A | scl=1, sda=0 (START condition)
// START_B | scl=0, sda=0
// ADDR    | 8 bit slots: {addr, rw} MSB first
// ACK_A   | address acknowledge slot (sda released, sampled)
// DATA    | 8 bit slots: wdata out, or read bits shifted in
// ACK_D   | data acknowledge slot (slave ACK on write, master NACK on read)
// STOP_A  | scl=0, sda=0
// STOP_B  | scl=1, sda=0
// STOP_C  | scl=1, sda released (STOP condition), then done
module i2c_master_byte #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] divisor,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [7:0]       wdata,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rdata,
    output logic             ack_err,
    output logic             scl,
    inout  wire              sda
);

    typedef enum logic [3:0] {
        IDLE, START_A, START_B, ADDR, ACK_A, DATA, ACK_D, STOP_A, STOP_B, STOP_C
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, div_q;
    logic [1:0]       quarter;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sh, rx_sh, wdata_q;
    logic             rw_q, nack, sda_low;
    logic             accept, phase_end, slot_end, sample, in_slot;

    // done is high in the first IDLE cycle; a start in that cycle is dropped.
    assign accept    = start && (state == IDLE) && !done;
    assign phase_end = (cnt == div_q);
    assign in_slot   = (state == ADDR) || (state == ACK_A) || (state == DATA) || (state == ACK_D);
    assign slot_end  = phase_end && (quarter == 2'd3);
    assign sample    = phase_end && (quarter == 2'd2);
    assign busy      = (state != IDLE);
    assign sda       = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl       = 1'b1;
        sda_low   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = START_A;
            START_A: begin
                sda_low = 1'b1;
                if (phase_end) state_nxt = START_B;
            end
            START_B: begin
                scl     = 1'b0;
                sda_low = 1'b1;
                if (phase_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl     = quarter[0] ^ quarter[1];
                sda_low = !tx_sh[7];
                if (slot_end && bit_cnt == 3'd7) state_nxt = ACK_A;
            end
            ACK_A: begin
                scl = quarter[0] ^ quarter[1];
                if (slot_end) state_nxt = nack ? STOP_A : DATA;
            end
            DATA: begin
                scl     = quarter[0] ^ quarter[1];
                sda_low = !rw_q && !tx_sh[7];
                if (slot_end && bit_cnt == 3'd7) state_nxt = ACK_D;
            end
            ACK_D: begin
                scl = quarter[0] ^ quarter[1];
                if (slot_end) state_nxt = STOP_A;
            end
            STOP_A: begin
                scl     = 1'b0;
                sda_low = 1'b1;
                if (phase_end) state_nxt = STOP_B;
            end
            STOP_B: begin
                sda_low = 1'b1;
                if (phase_end) state_nxt = STOP_C;
            end
            STOP_C:  if (phase_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            div_q   <= '0;
            quarter <= 2'd0;
            bit_cnt <= 3'd0;
            tx_sh   <= 8'h00;
            rx_sh   <= 8'h00;
            wdata_q <= 8'h00;
            rw_q    <= 1'b0;
            nack    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            ack_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt     <= '0;
                div_q   <= divisor;
                quarter <= 2'd0;
                bit_cnt <= 3'd0;
                tx_sh   <= {addr, rw};
                wdata_q <= wdata;
                rw_q    <= rw;
                nack    <= 1'b0;
                ack_err <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= phase_end ? '0 : cnt + DIV_W'(1);
                if (phase_end && in_slot) quarter <= quarter + 2'd1;
                // Receive sampling on the last cycle of Q2, while scl is high.
                if (sample) begin
                    if (state == ACK_A)                  nack  <= sda;
                    else if (state == ACK_D && !rw_q)    nack  <= sda;
                    else if (state == DATA && rw_q)      rx_sh <= {rx_sh[6:0], sda};
                end
                // Shifting at the end of Q3 presents the next bit at Q0 entry.
                if (slot_end) begin
                    if (state == ADDR || state == DATA) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end else if (state == ACK_A) begin
                        tx_sh <= wdata_q;
                    end
                end
                if (state == STOP_C && phase_end) begin
                    done    <= 1'b1;
                    ack_err <= nack;
                    if (rw_q && !nack) rdata <= rx_sh;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Testbench for i2c_master_byte: a behavioural slave/bus monitor decodes the
// scl/sda stream and answers ACKs and read data; expected latency, status
// and bit streams come from a transaction-level model.
module tb_i2c_master_byte;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DIV_W-1:0] divisor = '0;
    logic             start = 1'b0;
    logic [6:0]       addr = '0;
    logic             rw = 1'b0;
    logic [7:0]       wdata = '0;
    logic             busy, done, ack_err, scl;
    logic [7:0]       rdata;
    wire              sda;
    logic             slv_low = 1'b0;

    assign sda = slv_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_master_byte #(.DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .divisor(divisor), .start(start), .addr(addr),
        .rw(rw), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .ack_err(ack_err), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slave behaviour
    logic       cfg_ack_addr = 1'b1, cfg_ack_data = 1'b1, cfg_rw = 1'b0;
    logic [7:0] cfg_rdata = 8'h00;
    // bus monitor
    int   rises = 0;
    int   stops = 0;
    logic bus_bits [0:31];
    // model / observations
    logic [7:0] model_rdata = 8'h00;
    int         exp_cycles, exp_rises;
    logic       exp_err;
    logic [7:0] exp_addr_byte, exp_data_byte;
    int         got_cycles, stops_before;
    logic       got_timeout, side_change;

    // Slot index = scl rises seen so far when scl falls: 8 is the address
    // ACK, 9..16 data bits, 17 the data ACK.
    function automatic logic slave_drive(input int idx);
        if (!cfg_ack_addr) return 1'b0;
        if (idx == 8) return 1'b1;
        if (cfg_rw && idx >= 9 && idx <= 16) return !cfg_rdata[16-idx];
        if (!cfg_rw && idx == 17) return cfg_ack_data;
        return 1'b0;
    endfunction

    function automatic logic [7:0] bus_byte(input int first);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = bus_bits[first+i];
        return b;
    endfunction

    initial begin
        logic ps, pd, cs, cd;
        ps = 1'b1; pd = 1'b1;
        forever begin
            @(negedge clk);
            cs = (scl === 1'b1);
            cd = (sda !== 1'b0);
            if (cs && ps && pd && !cd) rises = 0;
            else if (cs && ps && !pd && cd) stops++;
            if (!ps && cs) begin
                if (rises < 32) bus_bits[rises] = cd;
                rises++;
            end
            if (ps && !cs) slv_low = slave_drive(rises);
            ps = cs; pd = cd;
        end
    end

    task automatic model_txn(input int div, input logic [6:0] a, input logic r, input logic [7:0] w);
        exp_cycles    = (div + 1) * (cfg_ack_addr ? 77 : 41);
        exp_rises     = cfg_ack_addr ? 19 : 10;   // bit clocks plus the STOP clock
        exp_err       = !cfg_ack_addr || (!r && !cfg_ack_data);
        if (r && cfg_ack_addr) model_rdata = cfg_rdata;
        exp_addr_byte = {a, r};
        exp_data_byte = r ? cfg_rdata : w;
    endtask

    task automatic run_txn(input int div, input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic mid_start);
        logic [7:0] prev_rdata;
        cfg_rw = r;
        model_txn(div, a, r, w);
        @(posedge clk); #1;
        divisor = DIV_W'(div); addr = a; rw = r; wdata = w; start = 1'b1;
        prev_rdata = rdata;
        @(posedge clk); #1;
        start = 1'b0;
        addr = ~a; rw = ~r; wdata = ~w; divisor = DIV_W'(div + 3);
        got_cycles = 0; side_change = 1'b0; stops_before = stops;
        while (done !== 1'b1 && got_cycles < 5000) begin
            start = (mid_start && got_cycles == 40);
            if (rdata !== prev_rdata || ack_err !== 1'b0 || busy !== 1'b1) side_change = 1'b1;
            @(posedge clk); #1;
            got_cycles++;
        end
        start = 1'b0;
        got_timeout = (done !== 1'b1);
    endtask

    task automatic test_reset();
        checks++; if (scl !== 1'b1)     begin errors++; $display("FAIL reset_scl got %b want 1", scl); end
        checks++; if (sda !== 1'b1)     begin errors++; $display("FAIL reset_sda got %b want released", sda); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (rdata !== 8'h00)  begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b want 0", ack_err); end
    endtask

    task automatic test_write();
        cfg_ack_addr = 1'b1; cfg_ack_data = 1'b1;
        run_txn(4, 7'h51, 1'b0, 8'hA5, 1'b0);
        checks++; if (got_timeout || got_cycles != 385) begin errors++; $display("FAIL write_latency got %0d want 385", got_cycles); end
        checks++; if (bus_byte(0) !== 8'hA2) begin errors++; $display("FAIL write_addr_byte got %h want a2", bus_byte(0)); end
        checks++; if (bus_byte(9) !== 8'hA5) begin errors++; $display("FAIL write_data_byte got %h want a5", bus_byte(9)); end
        checks++; if (bus_bits[8] !== 1'b0 || bus_bits[17] !== 1'b0) begin errors++; $display("FAIL write_ack_bits got %b%b want 00", bus_bits[8], bus_bits[17]); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL write_ack_err got %b want 0", ack_err); end
        checks++; if (rises != 19 || stops != stops_before + 1) begin errors++; $display("FAIL write_scl_rises got %0d stops %0d want 19 and 1 stop", rises, stops - stops_before); end
        checks++; if (side_change) begin errors++; $display("FAIL write_busy_status got change before done want stable"); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL write_done_pulse got done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_read();
        cfg_ack_addr = 1'b1; cfg_rdata = 8'h3C;
        run_txn(4, 7'h51, 1'b1, 8'h00, 1'b0);
        checks++; if (got_timeout || got_cycles != 385) begin errors++; $display("FAIL read_latency got %0d want 385", got_cycles); end
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata got %h want 3c", rdata); end
        checks++; if (bus_byte(0) !== 8'hA3) begin errors++; $display("FAIL read_addr_byte got %h want a3", bus_byte(0)); end
        checks++; if (bus_bits[17] !== 1'b1) begin errors++; $display("FAIL read_master_nack got %b want 1", bus_bits[17]); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL read_ack_err got %b want 0", ack_err); end
    endtask

    task automatic test_addr_nack();
        cfg_ack_addr = 1'b0;
        run_txn(4, 7'h12, 1'b1, 8'h00, 1'b0);
        checks++; if (got_timeout || got_cycles != 205) begin errors++; $display("FAIL anack_latency got %0d want 205", got_cycles); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL anack_ack_err got %b want 1", ack_err); end
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL anack_rdata got %h want 3c", rdata); end
        checks++; if (rises != 10 || stops != stops_before + 1) begin errors++; $display("FAIL anack_scl_rises got %0d want 10 with stop", rises); end
    endtask

    task automatic test_data_nack();
        cfg_ack_addr = 1'b1; cfg_ack_data = 1'b0;
        run_txn(4, 7'h51, 1'b0, 8'h0F, 1'b0);
        checks++; if (ack_err !== 1'b0 && got_cycles == 0) begin errors++; $display("FAIL dnack_clear got %b want 0", ack_err); end
        checks++; if (got_timeout || got_cycles != 385) begin errors++; $display("FAIL dnack_latency got %0d want 385", got_cycles); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL dnack_ack_err got %b want 1", ack_err); end
        checks++; if (side_change) begin errors++; $display("FAIL dnack_status got early change want ack_err cleared at start and held"); end
    endtask

    task automatic test_mid_start_div0();
        cfg_ack_addr = 1'b1; cfg_ack_data = 1'b1;
        run_txn(0, 7'h6B, 1'b0, 8'hC3, 1'b1);
        checks++; if (got_timeout || got_cycles != 77) begin errors++; $display("FAIL div0_latency got %0d want 77", got_cycles); end
        checks++; if (bus_byte(0) !== 8'hD6 || bus_byte(9) !== 8'hC3) begin errors++; $display("FAIL midstart_stream got %h %h want d6 c3", bus_byte(0), bus_byte(9)); end
    endtask

    task automatic test_back_to_back();
        cfg_ack_addr = 1'b1; cfg_ack_data = 1'b1;
        run_txn(1, 7'h20, 1'b0, 8'h81, 1'b0);
        start = 1'b1;   // same cycle as done: must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_done got busy %b want 0", busy); end
        run_txn(1, 7'h21, 1'b0, 8'h7E, 1'b0);
        checks++; if (got_timeout || got_cycles != 154 || bus_byte(0) !== 8'h42) begin errors++; $display("FAIL back_to_back got %0d cycles addr %h want 154 42", got_cycles, bus_byte(0)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int         div;
            logic [6:0] a;
            logic       r;
            logic [7:0] w;
            div = int'($urandom_range(0, 3));
            a = 7'($urandom); r = 1'($urandom); w = 8'($urandom);
            cfg_ack_addr = ($urandom_range(0, 3) != 0);
            cfg_ack_data = 1'($urandom);
            cfg_rdata    = 8'($urandom);
            run_txn(div, a, r, w, 1'b0);
            checks++; if (got_timeout || got_cycles != exp_cycles) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, got_cycles, exp_cycles); end
            checks++; if (ack_err !== exp_err || rdata !== model_rdata) begin errors++; $display("FAIL rand%0d_status got %b %h want %b %h", n, ack_err, rdata, exp_err, model_rdata); end
            checks++; if (bus_byte(0) !== exp_addr_byte || rises != exp_rises) begin errors++; $display("FAIL rand%0d_addr got %h rises %0d want %h %0d", n, bus_byte(0), rises, exp_addr_byte, exp_rises); end
            if (cfg_ack_addr) begin
                checks++; if (bus_byte(9) !== exp_data_byte) begin errors++; $display("FAIL rand%0d_data got %h want %h", n, bus_byte(9), exp_data_byte); end
            end
            repeat (int'($urandom_range(1, 4))) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        cfg_ack_addr = 1'b1; cfg_ack_data = 1'b1; cfg_rw = 1'b0;
        @(posedge clk); #1;
        divisor = 16'd2; addr = 7'h2A; rw = 1'b0; wdata = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; guard = 0;
        while (rises < 13 && guard < 2000) begin @(posedge clk); #1; guard++; end
        checks++; if (rises < 13) begin errors++; $display("FAIL rstmid_reach_data got %0d rises want 13", rises); end
        reset = 1'b1;
        #1;
        checks++; if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort got scl %b sda %b busy %b want 1 1 0", scl, sda, busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_rdata = 8'h00;
        run_txn(2, 7'h2A, 1'b0, 8'h5A, 1'b0);
        checks++; if (got_timeout || got_cycles != 231 || bus_byte(0) !== 8'h54 || bus_byte(9) !== 8'h5A || ack_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_clean got %0d %h %h %b want 231 54 5a 0", got_cycles, bus_byte(0), bus_byte(9), ack_err);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_mid_start_div0();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
